// File: rtl/bcd2bin_pkg.sv
// Shared types, constants and the round-robin pick helper for bcd2bin_arbiter.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_W   = 8;
    localparam int BIN_W   = 7;
    localparam int N_ITER  = 7;
    localparam int MAX_REQ = 8;

    // First set bit of req at or above ptr, wrapping modulo n.
    function automatic logic [2:0] next_rr(input logic [2:0] ptr,
                                           input logic [MAX_REQ-1:0] req,
                                           input int n);
        logic [2:0] w;
        logic       found;
        int         idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !found && req[idx]) begin
                w     = 3'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd2bin_serial_core.sv
// Reverse double-dabble engine: one right shift plus per-digit minus-3 per clock.
module bcd2bin_serial_core
    import bcd2bin_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [BCD_W-1:0] bcd,
    output logic [BIN_W-1:0] result,
    output logic             last
);

    logic [BCD_W+BIN_W-1:0] sr;
    logic [BCD_W+BIN_W-1:0] sr_next;
    logic [2:0]             cnt;

    always_comb begin
        sr_next = sr >> 1;
        if (sr_next[14:11] >= 4'd8) sr_next[14:11] = sr_next[14:11] - 4'd3;
        if (sr_next[10:7]  >= 4'd8) sr_next[10:7]  = sr_next[10:7]  - 4'd3;
    end

    // result is the post-shift value so the last iteration can be captured directly
    assign result = sr_next[BIN_W-1:0];
    assign last   = (cnt == 3'(N_ITER - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= 3'd7;
        end else if (load) begin
            sr  <= {bcd, {BIN_W{1'b0}}};
            cnt <= 3'd0;
        end else begin
            sr <= sr_next;
            if (cnt != 3'd7) cnt <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/bcd2bin_arbiter.sv
// Round-robin front end sharing one serial BCD-to-binary core among NUM_REQ requesters.
// Optional invalid-digit fast path enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd2bin_arbiter
    import bcd2bin_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   bcd_in,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [BIN_W-1:0]       bin_out,
    output logic                   err
);

    state_t             state, state_nx;
    logic [ID_W-1:0]    rr_ptr, id, sel;
    logic [BCD_W-1:0]   bcd_sel;
    logic [BIN_W-1:0]   core_result;
    logic               core_last;
    logic               any_req, load;
    logic [NUM_REQ-1:0] gnt_c;

    assign any_req = |req;
    assign sel     = ID_W'(next_rr(3'(rr_ptr), 8'(req), NUM_REQ));
    assign bcd_sel = bcd_in[8*int'(sel) +: 8];

`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic bad;
    logic err_q;
    assign bad = (bcd_sel[7:4] > 4'd9) || (bcd_sel[3:0] > 4'd9);
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        gnt_c    = '0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_c[sel] = 1'b1;
                    load       = 1'b1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                    state_nx   = bad ? DONE : SHIFT;
`else
                    state_nx   = SHIFT;
`endif
                end
            end
            SHIFT:   if (core_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Grant is decided combinationally in IDLE; gate it so nothing leaks out during reset.
    assign gnt  = gnt_c & {NUM_REQ{rst_n}};
    assign busy = rst_n & ((state != IDLE) | any_req);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id      <= '0;
            done_id <= '0;
            bin_out <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (load) begin
                id     <= sel;
                rr_ptr <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
            end
            // Results land on the edge into DONE so they are valid alongside done.
            if (state == SHIFT && core_last) begin
                bin_out <= core_result;
                done_id <= id;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                err_q   <= 1'b0;
`endif
            end
`ifdef BCD2BIN_DIGIT_CHECK_EN
            if (load && bad) begin
                bin_out <= '0;
                done_id <= sel;
                err_q   <= 1'b1;
            end
`endif
        end
    end

    bcd2bin_serial_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .bcd    (bcd_sel),
        .result (core_result),
        .last   (core_last)
    );

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Directed bench for bcd2bin_arbiter: vector table plus arbitration and reset sequences.
module tb_bcd2bin_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] bcd_in;
    logic [NUM_REQ-1:0]   gnt;
    logic                 busy, done, err;
    logic [ID_W-1:0]      done_id;
    logic [6:0]           bin_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int         r;
        logic [7:0] bcd;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    bcd2bin_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bcd_in(bcd_in), .gnt(gnt),
        .busy(busy), .done(done), .done_id(done_id), .bin_out(bin_out), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single request from requester r; expects grant now and done exp_lat cycles later.
    task automatic conv(input int r, input logic [7:0] b, input logic [6:0] e,
                        input bit chk_bin, input int exp_lat, input bit exp_err);
        int lat;
        lat = 0;
        bcd_in[8*r +: 8] = b;
        req = NUM_REQ'(1 << r);
        #1;
        chk("gnt", 32'(gnt), 32'(1 << r));
        chk("busy_at_gnt", 32'(busy), 1);
        @(negedge clk);
        req = '0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("latency", lat, exp_lat);
        if (lat != 0) begin
            chk("done_id", 32'(done_id), r);
            chk("err", 32'(err), 32'(exp_err));
            chk("busy_at_done", 32'(busy), 1);
            if (chk_bin) chk("bin_out", 32'(bin_out), 32'(e));
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        if (chk_bin) chk("bin_hold", 32'(bin_out), 32'(e));
    endtask

    initial begin
        int order[5];
        int gcnt, last_g, dcnt, early, seen_done, lat;
        logic [7:0] b;

        bcd_in = '0;
        vecs.push_back('{0, 8'h42, 7'd42});
        vecs.push_back('{1, 8'h99, 7'd99});
        vecs.push_back('{3, 8'h10, 7'd10});
        vecs.push_back('{0, 8'h00, 7'd0});
        vecs.push_back('{2, 8'h59, 7'd59});
        vecs.push_back('{1, 8'h07, 7'd7});
        vecs.push_back('{3, 8'h80, 7'd80});
        for (int t = 0; t < 10; t++)
            for (int u = 0; u < 10; u++)
                vecs.push_back('{2, 8'((t << 4) | u), 7'(10 * t + u)});

        // reset state
        do_reset();
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_id", 32'(done_id), 0);
        chk("rst_bin_out", 32'(bin_out), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clk);

        // vector table: hand values then full valid sweep on requester 2
        foreach (vecs[i]) conv(vecs[i].r, vecs[i].bcd, vecs[i].exp, 1'b1, 8, 1'b0);

        // all requesting continuously: order 0,1,2,3,0 nine cycles apart
        do_reset();
        bcd_in = {8'h78, 8'h56, 8'h34, 8'h12};
        req = 4'b1111;
        order = '{0, 1, 2, 3, 0};
        gcnt = 0; last_g = -1; dcnt = 0;
        for (int c = 0; c < 60 && gcnt < 5; c++) begin
            #1;
            if (done) begin
                chk("rr_done_id", 32'(done_id), (gcnt + 3) % 4);
                chk("rr_bin_out", 32'(bin_out), 12 + 22 * ((gcnt + 3) % 4));
                dcnt++;
            end
            if (gnt != 0) begin
                chk("rr_order", 32'(gnt), 32'(1 << order[gcnt]));
                if (last_g >= 0) chk("rr_spacing", c - last_g, 9);
                last_g = c;
                gcnt++;
            end
            @(negedge clk);
        end
        chk("rr_grant_count", gcnt, 5);
        chk("rr_done_count", dcnt, 4);
        req = '0;

        // late request waits until IDLE, granted the cycle after done
        do_reset();
        bcd_in = '0;
        bcd_in[15:8]  = 8'h25;
        bcd_in[31:24] = 8'h31;
        req = 4'b0010;
        #1;
        chk("late_gnt1", 32'(gnt), 32'h2);
        @(negedge clk);
        req = '0;
        early = 0; seen_done = 0;
        for (int c = 1; c < 20 && !seen_done; c++) begin
            if (c == 3) req = 4'b1000;
            #1;
            if (done) begin
                seen_done = 1;
                chk("late_bin1", 32'(bin_out), 25);
            end
            if (gnt != 0) early++;
            @(negedge clk);
        end
        chk("late_done_seen", seen_done, 1);
        chk("late_no_early_gnt", early, 0);
        #1;
        chk("late_gnt3", 32'(gnt), 32'h8);
        @(negedge clk);
        req = '0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin lat = k; break; end
            @(negedge clk);
        end
        chk("late_latency3", lat, 8);
        chk("late_id3", 32'(done_id), 3);
        chk("late_bin3", 32'(bin_out), 31);
        @(negedge clk);

        // reset mid-conversion aborts with no done
        do_reset();
        bcd_in[23:16] = 8'h59;
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_bin", 32'(bin_out), 0);
        chk("abort_id", 32'(done_id), 0);
        chk("abort_err", 32'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("abort_no_done", dcnt, 0);
        bcd_in = {8'h78, 8'h56, 8'h34, 8'h12};
        req = 4'b1111;
        #1;
        chk("abort_rr_ptr0", 32'(gnt), 32'h1);
        @(negedge clk);
        req = '0;
        repeat (10) @(negedge clk);

        // invalid digit
        b = 8'h3A;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        conv(0, b, 7'd0, 1'b1, 1, 1'b1);
        conv(1, 8'h42, 7'd42, 1'b1, 8, 1'b0);
`else
        conv(0, b, 7'd0, 1'b0, 8, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
